// File: rtl/alu_issue_wb.sv
// rtl/alu_issue_wb.sv - issue/writeback stage around the multi-cycle ALU execute stage
module alu_issue_wb #(
    parameter int          N       = 32,
    parameter int          MUL_LAT = 34,
    parameter int          SHF_LAT = 33,
    parameter int          ALU_LAT = 1,
    parameter logic [5:0]  IDLE_OP = 6'b111111
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_funct,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    output logic [5:0]    alu_oper,
    output logic [N-1:0]  alu_src0,
    output logic [N-1:0]  alu_src1,
    input  logic [N-1:0]  alu_dst_lo,
    input  logic [N-1:0]  alu_dst_hi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_lo,
    output logic [N-1:0]  out_hi,
    output logic          out_hi_we,
    output logic          out_err,
    output logic [N-1:0]  hi_reg,
    output logic [N-1:0]  lo_reg,
    output logic          busy
);

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_MUL  = 6'b000010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;

    // Counter holds "cycles left minus one", so LAT=1 gives a single EXEC cycle.
    localparam logic [5:0] MUL_LM1 = 6'(MUL_LAT - 1);
    localparam logic [5:0] SHF_LM1 = 6'(SHF_LAT - 1);
    localparam logic [5:0] ALU_LM1 = 6'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic        supported;
    logic [5:0]  lat_m1;
    logic        exec_mult;

    // Decode the incoming funct into "supported" and its latency class.
    always_comb begin
        supported = 1'b1;
        lat_m1    = ALU_LM1;
        case (in_funct)
            F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR: lat_m1 = ALU_LM1;
            F_MUL, F_MULT:                           lat_m1 = MUL_LM1;
            F_SLLV, F_SRLV:                          lat_m1 = SHF_LM1;
            default: begin
                supported = 1'b0;
                lat_m1    = 6'd0;
            end
        endcase
    end

    // alu_oper is held at the in-flight funct for all of EXEC, so it identifies MULT.
    assign exec_mult = (alu_oper == F_MULT);

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in EXEC, wait for downstream in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt = supported ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                if (cnt == 6'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand/oper launch, latency countdown, result capture and HI/LO update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_oper  <= IDLE_OP;
            alu_src0  <= '0;
            alu_src1  <= '0;
            cnt       <= 6'd0;
            out_lo    <= '0;
            out_hi    <= '0;
            out_hi_we <= 1'b0;
            out_err   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (supported) begin
                            alu_oper <= in_funct;
                            alu_src0 <= in_a;
                            alu_src1 <= in_b;
                            cnt      <= lat_m1;
                        end else begin
                            out_lo    <= '0;
                            out_hi    <= '0;
                            out_hi_we <= 1'b0;
                            out_err   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt == 6'd0) begin
                        out_lo    <= alu_dst_lo;
                        out_hi    <= exec_mult ? alu_dst_hi : '0;
                        out_hi_we <= exec_mult;
                        out_err   <= 1'b0;
                        if (exec_mult) begin
                            hi_reg <= alu_dst_hi;
                            lo_reg <= alu_dst_lo;
                        end
                        // Dropping back to IDLE_OP guarantees an oper edge before the next op.
                        alu_oper  <= IDLE_OP;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb/tb_alu_issue_wb.sv - directed bench with scoreboard model for alu_issue_wb
module tb_alu_issue_wb;

    localparam int         N       = 32;
    localparam int         MUL_LAT = 34;
    localparam int         SHF_LAT = 33;
    localparam int         ALU_LAT = 1;
    localparam logic [5:0] IDLE_OP = 6'b111111;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_MUL  = 6'b000010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_BAD  = 6'b001000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    in_funct = 6'd0;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic [5:0]    alu_oper;
    logic [N-1:0]  alu_src0;
    logic [N-1:0]  alu_src1;
    logic [N-1:0]  alu_dst_lo = '0;
    logic [N-1:0]  alu_dst_hi = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_lo;
    logic [N-1:0]  out_hi;
    logic          out_hi_we;
    logic          out_err;
    logic [N-1:0]  hi_reg;
    logic [N-1:0]  lo_reg;
    logic          busy;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    alu_issue_wb #(
        .N(N), .MUL_LAT(MUL_LAT), .SHF_LAT(SHF_LAT), .ALU_LAT(ALU_LAT), .IDLE_OP(IDLE_OP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
        .in_a(in_a), .in_b(in_b),
        .alu_oper(alu_oper), .alu_src0(alu_src0), .alu_src1(alu_src1),
        .alu_dst_lo(alu_dst_lo), .alu_dst_hi(alu_dst_hi),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lo(out_lo), .out_hi(out_hi), .out_hi_we(out_hi_we), .out_err(out_err),
        .hi_reg(hi_reg), .lo_reg(lo_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of an op: {hi, lo} as a 64-bit value.
    function automatic logic [63:0] op_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (f)
            F_ADD:  return {32'd0, a + b};
            F_SUB:  return {32'd0, a - b};
            F_MUL:  return {32'd0, p[31:0]};
            F_MULT: return p;
            F_AND:  return {32'd0, a & b};
            F_OR:   return {32'd0, a | b};
            F_XOR:  return {32'd0, a ^ b};
            F_NOR:  return {32'd0, ~(a | b)};
            F_SLLV: return {32'd0, b << a[4:0]};
            F_SRLV: return {32'd0, b >> a[4:0]};
            default: return 64'd0;
        endcase
    endfunction

    // Execute latency of an op; 0 marks an unsupported funct.
    function automatic int op_lat(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR: return ALU_LAT;
            F_MUL, F_MULT:                           return MUL_LAT;
            F_SLLV, F_SRLV:                          return SHF_LAT;
            default:                                 return 0;
        endcase
    endfunction

    // Execute-stage stand-in: the result only appears once oper has been held for LAT cycles.
    logic [5:0] last_oper = 6'd0;
    int         hold = 0;
    always @(negedge clk) begin
        logic [63:0] r;
        int          l;
        if (alu_oper !== last_oper) begin
            last_oper = alu_oper;
            hold = 0;
        end else begin
            hold++;
        end
        l = op_lat(alu_oper);
        r = op_result(alu_oper, alu_src0, alu_src1);
        if (l != 0 && hold >= l - 1) begin
            alu_dst_lo = r[31:0];
            alu_dst_hi = (alu_oper == F_MULT) ? r[63:32] :
                         (alu_oper == F_MUL)  ? 32'h5A5A5A5A : 32'hA5A5A5A5;
        end else begin
            alu_dst_lo = 32'hDEADBEEF;
            alu_dst_hi = 32'hBADC0FFE;
        end
    end

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        we;
        logic        err;
        int          due;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        e_valid;
    logic        e_exec;
    logic        was_empty;

    // Compare process: one op in flight at most; it is executing until its due cycle, then valid.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_hi = '0;
            m_lo = '0;
            chk("rst_ctrl", 64'({out_valid, out_err, out_hi_we, in_ready, busy}), 64'(5'b00010));
            chk("rst_oper", 64'(alu_oper), 64'(IDLE_OP));
            chk("rst_data", {out_lo, out_hi}, 64'd0);
            chk("rst_hilo", {hi_reg, lo_reg}, 64'd0);
        end else begin
            was_empty = (q.size() == 0);
            e_exec  = !was_empty && !q[0].err && (cyc < q[0].due);
            e_valid = !was_empty && (cyc >= q[0].due);
            if (e_valid && cyc == q[0].due && q[0].f == F_MULT) begin
                m_hi = q[0].hi;
                m_lo = q[0].lo;
            end
            chk("out_valid", 64'(out_valid), 64'(e_valid));
            chk("in_ready", 64'({in_ready, busy}), 64'({was_empty, !was_empty}));
            chk("alu_oper", 64'(alu_oper), 64'(e_exec ? q[0].f : IDLE_OP));
            if (e_exec) begin
                chk("alu_src", {alu_src0, alu_src1}, {q[0].a, q[0].b});
            end
            if (e_valid) begin
                chk("out_data", {out_hi, out_lo}, {q[0].hi, q[0].lo});
                chk("out_flags", 64'({out_hi_we, out_err}), 64'({q[0].we, q[0].err}));
            end
            chk("hilo", {hi_reg, lo_reg}, {m_hi, m_lo});
            if (e_valid && out_ready) begin
                void'(q.pop_front());
            end
            if (was_empty && in_valid) begin
                ent_t        e;
                logic [63:0] r;
                int          l;
                l     = op_lat(in_funct);
                r     = op_result(in_funct, in_a, in_b);
                e.f   = in_funct;
                e.a   = in_a;
                e.b   = in_b;
                e.err = (l == 0);
                e.lo  = e.err ? 32'd0 : r[31:0];
                e.hi  = (in_funct == F_MULT) ? r[63:32] : 32'd0;
                e.we  = (in_funct == F_MULT);
                e.due = cyc + l + 1;
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int acc);
        bit found;
        found = 0;
        acc = 0;
        in_valid = 1'b1;
        in_funct = f;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                found = 1;
                break;
            end
        end
        if (!found) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int acc, output int lat, output logic [31:0] lo, output logic [31:0] hi,
                               output logic we, output logic err);
        bit found;
        found = 0;
        lat = -1;
        lo = '0;
        hi = '0;
        we = 1'b0;
        err = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc;
                lo = out_lo;
                hi = out_hi;
                we = out_hi_we;
                err = out_err;
                found = 1;
                break;
            end
        end
        if (!found) chk("result_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          lat;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        we;
        logic        err;
        int          n_acc;
        int          n_start;
        int          idle_gap;
        logic [5:0]  prev_oper;
        bit          saw_valid;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ADD 5+7
        issue(F_ADD, 32'd5, 32'd7, acc);
        chk("add_oper_launch", 64'(alu_oper), 64'(6'b100000));
        wait_result(acc, lat, lo, hi, we, err);
        chk("add_lat", 64'(lat), 64'd2);
        chk("add_lo", 64'(lo), 64'd12);
        chk("add_we", 64'(we), 64'd0);

        // SUB 3-5
        @(posedge clk); #1;
        issue(F_SUB, 32'd3, 32'd5, acc);
        wait_result(acc, lat, lo, hi, we, err);
        chk("sub_lo", 64'(lo), 64'(32'hFFFFFFFE));
        chk("sub_err", 64'(err), 64'd0);

        // AND
        @(posedge clk); #1;
        issue(F_AND, 32'hF0F0_0000, 32'hFF00_FF00, acc);
        wait_result(acc, lat, lo, hi, we, err);
        chk("and_lo", 64'(lo), 64'(32'hF000_0000));

        // MULT -7*3
        @(posedge clk); #1;
        issue(F_MULT, 32'hFFFFFFF9, 32'd3, acc);
        wait_result(acc, lat, lo, hi, we, err);
        chk("mult_lat", 64'(lat), 64'(MUL_LAT + 1));
        chk("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        chk("mult_we", 64'(we), 64'd1);
        chk("mult_hilo", {hi_reg, lo_reg}, 64'hFFFFFFFF_FFFFFFEB);

        // MUL 6*7 leaves HI/LO alone
        @(posedge clk); #1;
        issue(F_MUL, 32'd6, 32'd7, acc);
        wait_result(acc, lat, lo, hi, we, err);
        chk("mul_res", {hi, lo}, 64'd42);
        chk("mul_we", 64'(we), 64'd0);
        @(negedge clk);
        chk("mul_hilo_kept", {hi_reg, lo_reg}, 64'hFFFFFFFF_FFFFFFEB);

        // SLLV 1 << 4
        @(posedge clk); #1;
        issue(F_SLLV, 32'd4, 32'd1, acc);
        wait_result(acc, lat, lo, hi, we, err);
        chk("sllv_lat", 64'(lat), 64'(SHF_LAT + 1));
        chk("sllv_lo", 64'(lo), 64'd16);

        // Back-to-back MULT with in_valid held high
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_funct = F_MULT;
        in_a = 32'd100000;
        in_b = 32'd300000;
        n_acc = 0;
        n_start = 0;
        idle_gap = 0;
        prev_oper = alu_oper;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (alu_oper == F_MULT && prev_oper != F_MULT) n_start++;
            if (n_start == 1 && alu_oper == IDLE_OP) idle_gap++;
            prev_oper = alu_oper;
            if (in_valid && in_ready) begin
                n_acc++;
                if (n_acc == 2) begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_accepts", 64'(n_acc), 64'd2);
        chk("b2b_oper_starts", 64'(n_start), 64'd2);
        chk("b2b_idle_gap", 64'(idle_gap >= 1), 64'd1);
        chk("b2b_hilo", {hi_reg, lo_reg}, 64'h00000006_FC23AC00);

        // Backpressure: out_ready low for 5 cycles of out_valid
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(F_XOR, 32'h0000_1234, 32'h0000_00FF, acc);
        wait_result(acc, lat, lo, hi, we, err);
        chk("bp_lat", 64'(lat), 64'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold", 64'({out_valid, in_ready}), 64'(2'b10));
            chk("bp_data", {out_hi, out_lo}, 64'h1234 ^ 64'h00FF);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("bp_release_idle", 64'({out_valid, in_ready}), 64'(2'b01));

        // Unsupported funct
        @(posedge clk); #1;
        issue(F_BAD, 32'd9, 32'd9, acc);
        chk("bad_oper_idle", 64'(alu_oper), 64'(IDLE_OP));
        wait_result(acc, lat, lo, hi, we, err);
        chk("bad_lat", 64'(lat), 64'd1);
        chk("bad_flags", 64'({err, we}), 64'(2'b10));
        chk("bad_lo", 64'(lo), 64'd0);

        // Reset mid-MULT
        @(posedge clk); #1;
        issue(F_MULT, 32'd9, 32'd9, acc);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ctrl", 64'({busy, in_ready, out_valid}), 64'(3'b010));
        chk("arst_oper", 64'(alu_oper), 64'(IDLE_OP));
        chk("arst_src", {alu_src0, alu_src1}, 64'd0);
        chk("arst_hilo", {hi_reg, lo_reg}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        chk("arst_abandoned", 64'(saw_valid), 64'd0);
        chk("arst_hilo_after", {hi_reg, lo_reg}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
